// File: rtl/neuron_input_loader_pkg.sv
// rtl/neuron_input_loader_pkg.sv - shared fixed-point element definitions used by neuron and its loader
package neuron_input_loader_pkg;

  // Q(INTEGER_WIDTH).(FRACTION_WIDTH) signed fixed-point sample
  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int FIXED_WIDTH    = INTEGER_WIDTH + FRACTION_WIDTH;

  // Element type shared by the neuron inputs and the loader lanes
  typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

endpackage

// File: rtl/neuron_input_loader.sv
// rtl/neuron_input_loader.sv - packs a serial sample stream into the parallel neuron input vector
module neuron_input_loader
  import neuron_input_loader_pkg::*;
#(
  parameter int NUM_INPUTS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  fixed_t                   in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output fixed_t [NUM_INPUTS-1:0]  inputs,
  output logic                     inputs_ready,
  input  logic                     output_ready
);

  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_INPUTS - 1);

  typedef enum logic {
    S_FILL    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CW-1:0]           count;
  fixed_t [NUM_INPUTS-1:0] lanes;

  // A sample is taken only while filling; the vector closes on the last lane or on in_last
  logic take;
  logic fill_done;

  assign take      = (state == S_FILL) && in_valid;
  assign fill_done = take && (in_last || (count == LAST_IDX));

  // State register, write pointer and lane storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_FILL;
      count <= '0;
      lanes <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        count <= count + CW'(1);
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (CW'(i) == count) begin
            lanes[i] <= in_data;
          end else if (fill_done && (CW'(i) > count)) begin
            // Short vector: lanes past the final sample must not leak the previous vector
            lanes[i] <= '0;
          end
        end
      end else if ((state == S_PRESENT) && output_ready) begin
        count <= '0;
      end
    end
  end

  // Next-state decode: output_ready only matters once the vector is presented
  always_comb begin
    state_next = state;
    case (state)
      S_FILL:    if (fill_done)    state_next = S_PRESENT;
      S_PRESENT: if (output_ready) state_next = S_FILL;
      default:                     state_next = S_FILL;
    endcase
  end

  // Outputs are pure state decodes; in_ready is held low while reset is asserted
  assign in_ready     = reset && (state == S_FILL);
  assign inputs_ready = (state == S_PRESENT);
  assign inputs       = lanes;

endmodule

// File: tb/tb_neuron_input_loader.sv
// tb/tb_neuron_input_loader.sv - scoreboard bench for neuron_input_loader
`timescale 1ns/100ps
module tb_neuron_input_loader;
  import neuron_input_loader_pkg::*;

  localparam int N = 4;

  logic              clock;
  logic              reset;
  fixed_t            in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  fixed_t [N-1:0]    inputs;
  logic              inputs_ready;
  logic              output_ready;

  neuron_input_loader #(.NUM_INPUTS(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .inputs       (inputs),
    .inputs_ready (inputs_ready),
    .output_ready (output_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [63:0] vec;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_ir = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising inputs_ready must match the oldest expected vector and cycle
  always @(negedge clock) begin
    if (reset && inputs_ready && !prev_ir) begin
      if (sb.size() == 0) begin
        check("unexpected_inputs_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("vec_data", inputs, e.vec);
        check("vec_latency", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_ir = inputs_ready;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic xfer(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    in_data  = 16'h0;
    tick();
  endtask

  // Expect the vector to appear after the next clock edge
  task automatic expect_vec(input logic [63:0] v);
    exp_t e;
    e.vec = v;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic release_vec();
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    check("release_inputs_ready", 64'(inputs_ready), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset        = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    output_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_inputs_ready", 64'(inputs_ready), 64'd0);
    check("rst_inputs", inputs, 64'd0);
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_inputs_ready", 64'(inputs_ready), 64'd0);

    // Full vector with continuous valid
    xfer(16'h0010, 1'b0);
    xfer(16'h0020, 1'b0);
    xfer(16'h0030, 1'b0);
    expect_vec(64'h0040_0030_0020_0010);
    xfer(16'h0040, 1'b0);
    check("present_in_ready", 64'(in_ready), 64'd0);

    // Hold: samples offered while presenting are ignored
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h7FFF;
      tick();
      check("hold_inputs", inputs, 64'h0040_0030_0020_0010);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_inputs_ready", 64'(inputs_ready), 64'd1);
    end
    in_valid = 1'b0;
    release_vec();

    // Short vector zero-fills lanes 2-3 left over from the previous vector
    xfer(16'h0005, 1'b0);
    expect_vec(64'h0000_0000_FFF0_0005);
    xfer(16'hFFF0, 1'b1);
    check("short_inputs_ready", 64'(inputs_ready), 64'd1);
    release_vec();

    // Bubbles: valid pattern 1,0,0,1,1,0,1
    xfer(16'h0001, 1'b0);
    bubble();
    bubble();
    xfer(16'h0002, 1'b0);
    xfer(16'h0003, 1'b0);
    bubble();
    check("bubble_not_ready", 64'(inputs_ready), 64'd0);
    expect_vec(64'h0004_0003_0002_0001);
    xfer(16'h0004, 1'b0);
    release_vec();

    // Asynchronous reset mid-fill, between clock edges
    xfer(16'hAAAA, 1'b0);
    xfer(16'hBBBB, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_inputs", inputs, 64'd0);
    check("async_rst_inputs_ready", 64'(inputs_ready), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    #3;
    reset = 1'b1;
    tick();
    xfer(16'h1111, 1'b0);
    xfer(16'h2222, 1'b0);
    xfer(16'h8000, 1'b0);
    expect_vec(64'hFFFF_8000_2222_1111);
    xfer(16'hFFFF, 1'b0);
    release_vec();

    // Stale output_ready held high through FILL
    output_ready = 1'b1;
    xfer(16'h0101, 1'b0);
    xfer(16'h0202, 1'b0);
    xfer(16'h0303, 1'b0);
    check("stale_no_skip", 64'(inputs_ready), 64'd0);
    expect_vec(64'h0404_0303_0202_0101);
    xfer(16'h0404, 1'b0);
    check("stale_present", 64'(inputs_ready), 64'd1);
    tick();
    check("stale_exit_inputs_ready", 64'(inputs_ready), 64'd0);
    check("stale_exit_in_ready", 64'(in_ready), 64'd1);
    output_ready = 1'b0;

    tick();
    tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
